// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues instruction memory requests at the
// current PC, delivers fetched words to IF/ID, and steers the PC register
// through sequential advance, stall hold and branch/jump redirects.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | first cycle after reset release, no request outstanding
// FETCH | request at pcOut outstanding, waiting for imemAck
// ADV   | PC register being written (pcWrite=1) this cycle
// HOLD  | word captured while stalled, waiting for stall to drop
// DROP  | redirected while request outstanding; response is discarded
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcOut,
    output logic        pcWrite,
    output logic [31:0] pcIn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instOut,
    output logic        instValid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ADV   = 3'd2,
        HOLD  = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [31:0] saved_pc, saved_pc_nx;
    logic [31:0] pc_in_nx, inst_out_nx;
    logic        pc_write_nx, inst_valid_nx;
    logic [31:0] target_pc;
    logic [31:0] seq_pc;

    // Branch targets are word aligned; the adder wraps naturally at 2^32.
    assign target_pc = redirectPc & 32'hFFFF_FFFC;
    assign seq_pc    = pcOut + 32'd4;

    // Request is driven straight from state so it drops the moment a
    // response is taken or reset hits.
    assign imemReq  = (state == FETCH) || (state == DROP);
    assign imemAddr = pcOut;

    // Next-state and next-output decode; redirect outranks stall and delivery.
    always_comb begin
        state_nx      = state;
        pc_write_nx   = 1'b0;
        pc_in_nx      = pcIn;
        inst_out_nx   = instOut;
        inst_valid_nx = 1'b0;
        saved_pc_nx   = saved_pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_nx    = ADV;
                    pc_write_nx = 1'b1;
                    pc_in_nx    = target_pc;
                end else begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                if (imemAck) begin
                    if (redirect) begin
                        state_nx    = ADV;
                        pc_write_nx = 1'b1;
                        pc_in_nx    = target_pc;
                    end else if (stall) begin
                        state_nx    = HOLD;
                        inst_out_nx = imemData;
                    end else begin
                        state_nx      = ADV;
                        inst_out_nx   = imemData;
                        inst_valid_nx = 1'b1;
                        pc_write_nx   = 1'b1;
                        pc_in_nx      = seq_pc;
                    end
                end else if (redirect) begin
                    // Memory cannot abort, so remember the target and
                    // swallow the response when it arrives.
                    state_nx    = DROP;
                    saved_pc_nx = target_pc;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nx    = ADV;
                    pc_write_nx = 1'b1;
                    pc_in_nx    = target_pc;
                end else if (!stall) begin
                    state_nx      = ADV;
                    inst_valid_nx = 1'b1;
                    pc_write_nx   = 1'b1;
                    pc_in_nx      = seq_pc;
                end
            end
            ADV: begin
                if (redirect) begin
                    state_nx    = ADV;
                    pc_write_nx = 1'b1;
                    pc_in_nx    = target_pc;
                end else begin
                    state_nx = FETCH;
                end
            end
            DROP: begin
                if (imemAck) begin
                    state_nx    = ADV;
                    pc_write_nx = 1'b1;
                    pc_in_nx    = redirect ? target_pc : saved_pc;
                end else if (redirect) begin
                    saved_pc_nx = target_pc;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pcWrite   <= 1'b0;
            pcIn      <= RESET_PC;
            instOut   <= 32'h0000_0000;
            instValid <= 1'b0;
            saved_pc  <= 32'h0000_0000;
        end else begin
            state     <= state_nx;
            pcWrite   <= pc_write_nx;
            pcIn      <= pc_in_nx;
            instOut   <= inst_out_nx;
            instValid <= inst_valid_nx;
            saved_pc  <= saved_pc_nx;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register around it.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pcOut;
    logic        pcWrite;
    logic [31:0] pcIn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instOut;
    logic        instValid;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcOut      (pcOut),
        .pcWrite    (pcWrite),
        .pcIn       (pcIn),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .instOut    (instOut),
        .instValid  (instValid)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock from negedge to negedge; the PC register loads pcIn when
    // pcWrite was high across the edge.
    task automatic cyc();
        logic        w;
        logic [31:0] p;
        w = pcWrite;
        p = pcIn;
        @(posedge clk);
        #1;
        if (w) pcOut = p;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        pcOut      = 32'h0;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        imemAck    = 1'b0;
        imemData   = 32'h0;

        // Reset values
        #3;
        chk("rst_pcwrite", {31'b0, pcWrite}, 32'h0);
        chk("rst_pcin", pcIn, 32'h0);
        chk("rst_valid", {31'b0, instValid}, 32'h0);
        chk("rst_inst", instOut, 32'h0);
        chk("rst_req", {31'b0, imemReq}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("idle_to_fetch_req", {31'b0, imemReq}, 32'h1);
        chk("fetch0_addr", imemAddr, 32'h0);

        // Zero-latency ack
        imemAck = 1'b1; imemData = 32'h1111_1111;
        cyc();
        chk("d0_valid", {31'b0, instValid}, 32'h1);
        chk("d0_inst", instOut, 32'h1111_1111);
        chk("d0_pcwrite", {31'b0, pcWrite}, 32'h1);
        chk("d0_pcin", pcIn, 32'h4);
        chk("d0_adv_req", {31'b0, imemReq}, 32'h0);
        imemAck = 1'b0;
        cyc();
        chk("d0_next_req", {31'b0, imemReq}, 32'h1);
        chk("d0_next_addr", imemAddr, 32'h4);
        chk("d0_next_pcwrite", {31'b0, pcWrite}, 32'h0);
        chk("d0_next_valid", {31'b0, instValid}, 32'h0);

        // Stall across ack
        imemAck = 1'b1; imemData = 32'hAAAA_0000; stall = 1'b1;
        cyc();
        imemAck = 1'b0; imemData = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pcwrite", {31'b0, pcWrite}, 32'h0);
            chk("stall_valid", {31'b0, instValid}, 32'h0);
            chk("stall_req", {31'b0, imemReq}, 32'h0);
            if (i < 2) cyc();
        end
        stall = 1'b0;
        cyc();
        chk("unstall_valid", {31'b0, instValid}, 32'h1);
        chk("unstall_inst", instOut, 32'hAAAA_0000);
        chk("unstall_pcin", pcIn, 32'h8);
        chk("unstall_pcwrite", {31'b0, pcWrite}, 32'h1);
        cyc();
        chk("unstall_next_addr", imemAddr, 32'h8);

        // Redirect with 3-cycle ack latency
        redirect = 1'b1; redirectPc = 32'h400;
        cyc();
        redirect = 1'b0;
        chk("drop1_req", {31'b0, imemReq}, 32'h1);
        chk("drop1_pcwrite", {31'b0, pcWrite}, 32'h0);
        cyc();
        chk("drop2_req", {31'b0, imemReq}, 32'h1);
        chk("drop2_valid", {31'b0, instValid}, 32'h0);
        imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
        cyc();
        imemAck = 1'b0;
        chk("drop_pcwrite", {31'b0, pcWrite}, 32'h1);
        chk("drop_pcin", pcIn, 32'h400);
        chk("drop_valid", {31'b0, instValid}, 32'h0);
        chk("drop_inst_kept", instOut, 32'hAAAA_0000);
        cyc();
        chk("drop_next_addr", imemAddr, 32'h400);

        // Latest redirect wins in DROP
        redirect = 1'b1; redirectPc = 32'h400;
        cyc();
        redirectPc = 32'h800;
        cyc();
        redirect = 1'b0;
        chk("latest_no_pcwrite", {31'b0, pcWrite}, 32'h0);
        imemAck = 1'b1;
        cyc();
        imemAck = 1'b0;
        chk("latest_pcin", pcIn, 32'h800);
        cyc();
        chk("latest_addr", imemAddr, 32'h800);

        // Redirect with ack in FETCH; PC wrap
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFF; imemAck = 1'b1; imemData = 32'h0BAD_0BAD;
        cyc();
        redirect = 1'b0; imemAck = 1'b0;
        chk("rdack_pcin", pcIn, 32'hFFFF_FFFC);
        chk("rdack_valid", {31'b0, instValid}, 32'h0);
        cyc();
        chk("wrap_addr", imemAddr, 32'hFFFF_FFFC);
        imemAck = 1'b1; imemData = 32'h1234_5678;
        cyc();
        imemAck = 1'b0;
        chk("wrap_pcin", pcIn, 32'h0);
        chk("wrap_inst", instOut, 32'h1234_5678);
        cyc();
        redirect = 1'b1; redirectPc = 32'h403; imemAck = 1'b1; imemData = 32'h9999_9999;
        cyc();
        redirect = 1'b0; imemAck = 1'b0;
        chk("align_pcin", pcIn, 32'h400);
        chk("align_inst_kept", instOut, 32'h1234_5678);
        cyc();

        // Redirect arriving together with the ack in DROP
        redirect = 1'b1; redirectPc = 32'h100;
        cyc();
        imemAck = 1'b1; redirectPc = 32'h803;
        cyc();
        imemAck = 1'b0; redirect = 1'b0;
        chk("drop_same_pcin", pcIn, 32'h800);
        cyc();

        // Redirect in ADV
        imemAck = 1'b1; imemData = 32'h0000_0055;
        cyc();
        imemAck = 1'b0;
        chk("adv_pcin_seq", pcIn, 32'h804);
        redirect = 1'b1; redirectPc = 32'h200;
        cyc();
        redirect = 1'b0;
        chk("adv_rd_pcwrite", {31'b0, pcWrite}, 32'h1);
        chk("adv_rd_pcin", pcIn, 32'h200);
        chk("adv_rd_valid", {31'b0, instValid}, 32'h0);
        cyc();
        chk("adv_rd_addr", imemAddr, 32'h200);

        // Asynchronous reset mid-FETCH, then late ack ignored
        #2;
        rst = 1'b0;
        pcOut = 32'h0;
        #1;
        chk("arst_req", {31'b0, imemReq}, 32'h0);
        chk("arst_pcin", pcIn, 32'h0);
        chk("arst_inst", instOut, 32'h0);
        chk("arst_valid", {31'b0, instValid}, 32'h0);
        chk("arst_pcwrite", {31'b0, pcWrite}, 32'h0);
        @(negedge clk);
        imemAck = 1'b1; imemData = 32'h0000_0077;
        rst = 1'b1;
        cyc();
        chk("late_valid", {31'b0, instValid}, 32'h0);
        chk("late_pcwrite", {31'b0, pcWrite}, 32'h0);
        chk("late_req", {31'b0, imemReq}, 32'h1);
        chk("late_addr", imemAddr, 32'h0);
        imemData = 32'h0000_0066;
        cyc();
        imemAck = 1'b0;
        chk("restart_valid", {31'b0, instValid}, 32'h1);
        chk("restart_inst", instOut, 32'h0000_0066);
        chk("restart_pcin", pcIn, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
